// File: rtl/video_pkg.sv
// Shared definitions for the IO-mapped video blocks: port addresses, default
// 640x480 raster timing, control bit positions and the status byte layout.
package video_pkg;

    localparam logic [7:0] IO_PORT_COMPOSITOR = 8'h20;
    localparam logic [7:0] IO_PORT_TIMING     = 8'h21;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQEN  = 1;
    localparam int CTRL_IRQCLR = 7;

    typedef struct packed {
        logic       irq_pending;
        logic       in_vblank;
        logic       in_hblank;
        logic [2:0] rsvd;
        logic       irq_en;
        logic       enable;
    } vtg_status_t;

    // True when lo <= pos < hi; done in int so hi may reach 1024.
    function automatic logic in_window(input logic [9:0] pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// IO bus shared by the IO-mapped video blocks: active-low write/read strobes,
// 16-bit address (low byte decoded), 8-bit data each way.
interface video_timing_gen_if;
    logic        io_in;
    logic        io_rd;
    logic [15:0] io_address_in;
    logic [7:0]  io_data_in;
    logic [7:0]  io_data_out;

    modport master (
        output io_in, io_rd, io_address_in, io_data_in,
        input  io_data_out
    );

    modport slave (
        input  io_in, io_rd, io_address_in, io_data_in,
        output io_data_out
    );
endinterface

// File: rtl/video_timing_gen_io_port_slave.sv
// Single-register IO port: one write pulse per low strobe, and a status byte
// latched on the first cycle of a matching read and held while io_rd is low.
module io_port_slave
    import video_pkg::*;
#(
    parameter logic [7:0] PORT_ADDR = IO_PORT_TIMING
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_in,
    input  logic        io_rd,
    input  logic [15:0] io_address_in,
    input  logic [7:0]  io_data_in,
    input  logic [7:0]  rd_status,
    output logic        wr_stb,
    output logic [7:0]  wr_data,
    output logic [7:0]  io_data_out
);

    logic       wr_ack_q, wr_ack_d;
    logic       rd_ack_q, rd_ack_d;
    logic [7:0] data_out_q, data_out_d;
    logic       sel;
    logic       unused_addr_hi;

    assign sel            = (io_address_in[7:0] == PORT_ADDR);
    assign unused_addr_hi = ^io_address_in[15:8];
    assign wr_stb         = !io_in && !wr_ack_q && sel;
    assign wr_data        = io_data_in;
    assign io_data_out    = data_out_q;

    always_comb begin
        wr_ack_d   = !io_in;
        rd_ack_d   = !io_rd;
        data_out_d = data_out_q;
        if (io_rd) begin
            data_out_d = '0;
        end else if (!rd_ack_q && sel) begin
            data_out_d = rd_status;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable, X/Y counters, syncs, display
// window, frame-start strobe and vblank interrupt, controlled over one IO port.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int         H_ACTIVE = DEF_H_ACTIVE,
    parameter int         H_FP     = DEF_H_FP,
    parameter int         H_SYNC   = DEF_H_SYNC,
    parameter int         H_BP     = DEF_H_BP,
    parameter int         V_ACTIVE = DEF_V_ACTIVE,
    parameter int         V_FP     = DEF_V_FP,
    parameter int         V_SYNC   = DEF_V_SYNC,
    parameter int         V_BP     = DEF_V_BP,
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] IO_PORT  = IO_PORT_TIMING
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_ce,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       inDisplayArea,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       frame_start,
    output logic       vblank_irq,
    input  logic       irq_ack,
    video_timing_gen_if.slave io
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_IRQ    = 10'(V_ACTIVE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       cnt_x_q, cnt_x_d;
    logic [9:0]       cnt_y_q, cnt_y_d;
    logic             disp_q, disp_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;
    logic             irq_q, irq_d;
    logic             enable_q, enable_d;
    logic             irq_en_q, irq_en_d;

    logic             wr_stb;
    logic [7:0]       wr_data;
    vtg_status_t      status;
    logic             unused_wr_bits;

    assign pix_ce         = enable_q && (div_q == DIV_LAST);
    assign unused_wr_bits = ^wr_data[6:2];

    assign status = '{
        irq_pending: irq_q,
        in_vblank:   (int'(cnt_y_q) >= V_ACTIVE),
        in_hblank:   (int'(cnt_x_q) >= H_ACTIVE),
        rsvd:        3'b000,
        irq_en:      irq_en_q,
        enable:      enable_q
    };

    io_port_slave #(
        .PORT_ADDR (IO_PORT)
    ) u_io (
        .clk           (clk),
        .reset_n       (reset_n),
        .io_in         (io.io_in),
        .io_rd         (io.io_rd),
        .io_address_in (io.io_address_in),
        .io_data_in    (io.io_data_in),
        .rd_status     (status),
        .wr_stb        (wr_stb),
        .wr_data       (wr_data),
        .io_data_out   (io.io_data_out)
    );

    // Disabled holds the raster at its reset point so re-enable restarts at (0,0).
    always_comb begin
        div_d   = div_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (!enable_q) begin
            div_d   = '0;
            cnt_x_d = H_LAST;
            cnt_y_d = V_LAST;
        end else if (pix_ce) begin
            div_d = '0;
            if (cnt_x_q == H_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (cnt_y_q == V_LAST) ? 10'd0 : cnt_y_q + 10'd1;
            end else begin
                cnt_x_d = cnt_x_q + 10'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Decoded outputs come from the next counter values so they move with X/Y.
    always_comb begin
        disp_d = in_window(cnt_x_d, 0, H_ACTIVE) && in_window(cnt_y_d, 0, V_ACTIVE);
        hs_d   = !in_window(cnt_x_d, HS_START, HS_START + H_SYNC);
        vs_d   = !in_window(cnt_y_d, VS_START, VS_START + V_SYNC);
        fs_d   = pix_ce && (cnt_x_d == '0) && (cnt_y_d == '0);

        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (wr_stb) begin
            enable_d = wr_data[CTRL_EN];
            irq_en_d = wr_data[CTRL_IRQEN];
        end

        irq_d = irq_q;
        if (irq_ack || (wr_stb && wr_data[CTRL_IRQCLR])) begin
            irq_d = 1'b0;
        end
        if (pix_ce && irq_en_q && (cnt_x_d == '0) && (cnt_y_d == V_IRQ)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            cnt_x_q  <= H_LAST;
            cnt_y_q  <= V_LAST;
            disp_q   <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
            irq_q    <= 1'b0;
            enable_q <= 1'b1;
            irq_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_x_q  <= cnt_x_d;
            cnt_y_q  <= cnt_y_d;
            disp_q   <= disp_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            irq_q    <= irq_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign CounterX      = cnt_x_q;
    assign CounterY      = cnt_y_q;
    assign inDisplayArea = disp_q;
    assign vga_h_sync    = hs_q;
    assign vga_v_sync    = vs_q;
    assign frame_start   = fs_q;
    assign vblank_irq    = irq_q;

endmodule
